// File: rtl/out_arb_mux_pkg.sv
// out_arb_mux_pkg
//   Shared definitions for the output arbiter/mux slice:
//   - arb_mode_e   : arbitration mode encoding (fixed priority / round-robin)
//   - CH_MEM/CH_ALU: channel index assignments on the merged output bus
//   - clog2_min1   : ceil(log2(n)) clamped to at least 1, used for index widths
package out_arb_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int CH_MEM = 0;
  localparam int CH_ALU = 1;

  // A single channel still needs a 1-bit index so port widths never collapse to 0.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/out_arb_mux_rr_arbiter.sv
// rr_arbiter
//   Purely combinational request arbiter.
//   Parameters: NUM_CH (channel count), ARB_MODE (0 fixed priority, 1 round-robin).
//   Ports:
//     req     in  NUM_CH : per-channel request
//     ptr     in  CH_W   : highest-priority channel in round-robin mode
//     gnt     out NUM_CH : one-hot grant, zero when no request
//     gnt_idx out CH_W   : encoded grant index, zero when no request
//   The pointer register belongs to the parent; this block only searches.
module rr_arbiter
  import out_arb_mux_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = 0,
  localparam int CH_W    = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  always_comb begin : search
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Fixed mode scans from channel 0; round-robin scans from ptr with wrap.
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == int'(ARB_RR)) ? ((int'(ptr) + k) % NUM_CH) : k;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/out_arb_mux.sv
// out_arb_mux
//   Registered result selector merging NUM_CH producer channels onto the
//   system output bus with valid/ready on every side.
//   Parameters: NUM_CH (2..8), DATA_W, ARB_MODE (0 fixed, 1 round-robin).
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     in_valid  in  NUM_CH        : channel offers data
//     in_data   in  NUM_CH*DATA_W : channel i at [i*DATA_W +: DATA_W]
//     in_ready  out NUM_CH        : one-hot/zero accept, combinational
//     out_valid out 1             : output register holds a result
//     out_data  out DATA_W        : registered result
//     out_src   out CH_W          : source channel of out_data
//     out_ready in  1             : consumer takes the result
module out_arb_mux
  import out_arb_mux_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 20,
  parameter int ARB_MODE = 0,
  localparam int CH_W    = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_src,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   ptr_nxt;
  logic [DATA_W-1:0] sel_data;
  logic              load;
  logic              any_req;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [CH_W-1:0]   src_p0;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The register can take a new entry when empty or drained on this same edge.
  assign load     = !vld_p0 || out_ready;
  assign any_req  = |in_valid;
  assign in_ready = (load && any_req) ? gnt : '0;
  assign sel_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign ptr_nxt  = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // Stage p0: output register; data/src hold when the register empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      src_p0  <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      vld_p0 <= any_req;
      if (any_req) begin
        data_p0 <= sel_data;
        src_p0  <= gnt_idx;
        rr_ptr  <= ptr_nxt;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_src   = src_p0;

endmodule
